ucode_sequencer: RTL and testbench
==================================

Name: ucode_sequencer

Overview:
- Sits directly downstream of instruction fetch, between fetch and decode.
- Receives the filtered instruction from fetch and passes ordinary instructions through to decode as registered micro-ops.
- Expands two macro instructions (MUL, SWP) into fixed-length micro-op sequences.
- Drives the `control` handshake that makes fetch freeze the PC for the whole expansion, so decode only ever sees micro-ops.

Parameters:
- MUL_OPC, 7'b1010000, macro opcode for multiply expansion
- SWP_OPC, 7'b1010001, macro opcode for register-swap expansion
- UOP_OPC, 7'b1111000, opcode placed in bits [31:25] of every generated micro-op
- MUL_LEN, 16, micro-ops emitted for MUL (legal range 2..31)
- SWP_LEN, 3, micro-ops emitted for SWP (legal range 2..31)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- inst_in  in  32  instruction from fetch (filteredInstruction)
- flush  in  1  execute redirect (same signal as fetch's exeOverride); squashes the current slot
- control  out  1  combinational; high = fetch must hold PC and enter/stay in its microcode state
- uop  out  32  registered micro-op or pass-through instruction to decode
- uop_valid  out  1  registered; uop is valid this cycle
- busy  out  1  registered; high while state is RUN or DONE

Behaviour:
- Reset (async, immediate): state=IDLE, step=0, latched fields=0, uop=0, uop_valid=0, busy=0. control is forced 0 while rst is high.
- Opcode is inst_in[31:25]. Macro field positions: rd=[24:21], rs1=[20:17], rs2=[16:13].
- Micro-op encoding:
  - [31:25]=UOP_OPC, [24:21]=rd, [20:17]=rs1, [16:13]=rs2
  - [12:10]=macro id (3'b001 MUL, 3'b010 SWP)
  - [9:5]=step, [4:0]=0
- Step counter is 5 bits. LEN is MUL_LEN or SWP_LEN, selected at detection.

States:
- IDLE
  - Macro opcode and !flush:
    - control=1 (combinational, same cycle, so fetch freezes PC at that edge).
    - Latch rd, rs1, rs2, id and LEN.
    - At the edge: uop <= step-0 encoding, uop_valid <= 1, step <= 1, go to RUN.
  - Non-macro and !flush: control=0; at the edge uop <= inst_in, uop_valid <= 1.
  - flush=1: control=0, no detection; uop <= 0, uop_valid <= 0.
- RUN
  - Every cycle: uop <= encoding(step), uop_valid <= 1, step <= step+1.
  - control=1 except in the cycle where step==LEN-1 (the last issue), where control=0; fetch therefore returns to its filter state one cycle after the last issue.
  - After issuing step LEN-1: go to DONE.
  - inst_in is ignored in RUN; latched fields are used.
- DONE (exactly one cycle)
  - Fetch presents the same macro at the same PC and advances PC+4 this cycle.
  - Sequencer ignores inst_in: control=0, uop <= 0, uop_valid <= 0, step <= 0, go to IDLE.
  - This state prevents re-triggering on the instruction just expanded.
- Timing for a macro detected in cycle T:
  - control high T..T+LEN-2, low T+LEN-1.
  - Micro-ops valid at edges ending cycles T..T+LEN-1.
  - DONE at T+LEN; IDLE at T+LEN+1.
- flush in RUN: control=0 that cycle; uop <= 0, uop_valid <= 0; go to DONE (remaining steps discarded, PC not re-expanded).
- flush in DONE: no extra effect.
- Back-to-back macros: a second macro presented in the IDLE cycle after DONE is detected normally.
- rst asserted mid-RUN: outputs clear immediately; no partial sequence resumes after release.
- busy is registered: 1 on the edge entering RUN, 0 on the edge entering IDLE.

Test Plan:
1. Pass-through: inst_in=0x12345678, flush=0 -> control=0; next edge uop=0x12345678, uop_valid=1; busy stays 0.
2. SWP (opcode 1010001, rd=3, rs1=5, rs2=7), held from cycle T:
   - control=1 at T and T+1, 0 at T+2.
   - uop=0xF06AE800, 0xF06AE820, 0xF06AE840 on three consecutive edges, all valid.
   - T+3: uop_valid=0 and control=0 despite the same inst_in.
   - T+4: re-detect allowed.
3. MUL (default params): control high 15 cycles then low. 16 valid micro-ops with id=001, step field 0..15 (last uop[9:5]=5'd15). One DONE bubble follows.
4. Flush at RUN step 2 of MUL: control=0 that cycle; next edge uop_valid=0; DONE then IDLE; total valid MUL micro-ops = 2.
5. flush=1 in IDLE with MUL opcode on inst_in -> control=0, uop_valid=0 next edge, state stays IDLE.
6. rst asserted asynchronously mid-SWP (between edges) -> uop=0, uop_valid=0, control=0, busy=0 before the next edge. After release with a non-macro instruction, pass-through resumes on the first edge.

Source files
------------

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: sits between fetch and decode. Ordinary instructions pass
// through as registered micro-ops. The MUL and SWP macros expand into
// fixed-length micro-op sequences while fetch holds its PC.
//
// Handshake with fetch: `control` is combinational. While it is high, fetch
// holds the PC and stays in its microcode state. It rises in the same cycle a
// macro is detected, so fetch freezes at that edge. It drops in the cycle of
// the last issue, so fetch is back in its filter state one cycle later.
// uop/uop_valid form a registered, always-accepted output: decode consumes
// every cycle in which uop_valid is high, and there is no back-pressure.
module ucode_sequencer #(
  parameter logic [6:0] MUL_OPC = 7'b1010000,
  parameter logic [6:0] SWP_OPC = 7'b1010001,
  parameter logic [6:0] UOP_OPC = 7'b1111000,
  parameter int unsigned MUL_LEN = 16,
  parameter int unsigned SWP_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic        flush,
  output logic        control,
  output logic [31:0] uop,
  output logic        uop_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [2:0] ID_MUL = 3'b001;
  localparam logic [2:0] ID_SWP = 3'b010;
  localparam logic [4:0] MUL_LEN5 = 5'(MUL_LEN);
  localparam logic [4:0] SWP_LEN5 = 5'(SWP_LEN);

  state_e      state_q, state_d;
  logic [4:0]  step_q, step_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  rs1_q, rs1_d;
  logic [3:0]  rs2_q, rs2_d;
  logic [2:0]  id_q, id_d;
  logic [4:0]  len_q, len_d;
  logic [31:0] uop_q, uop_d;
  logic        uop_valid_q, uop_valid_d;
  logic        busy_q, busy_d;
  logic        control_c;

  // Decode the incoming instruction's macro fields.
  logic [6:0] opc;
  logic       is_mul;
  logic       is_swp;
  logic       last_step;

  assign opc       = inst_in[31:25];
  assign is_mul    = (opc == MUL_OPC);
  assign is_swp    = (opc == SWP_OPC);
  assign last_step = (step_q == (len_q - 5'd1));

  // Build one micro-op word from the latched fields and a step index.
  function automatic logic [31:0] encode(input logic [3:0] rd,
                                         input logic [3:0] rs1,
                                         input logic [3:0] rs2,
                                         input logic [2:0] id,
                                         input logic [4:0] step);
    return {UOP_OPC, rd, rs1, rs2, id, step, 5'b00000};
  endfunction

  // Next-state and output logic. Every path clears uop/uop_valid unless it
  // issues something.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    id_d        = id_q;
    len_d       = len_q;
    uop_d       = 32'd0;
    uop_valid_d = 1'b0;
    control_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          if (is_mul || is_swp) begin
            // Macro detected: latch operands and issue step 0 immediately.
            rd_d        = inst_in[24:21];
            rs1_d       = inst_in[20:17];
            rs2_d       = inst_in[16:13];
            id_d        = is_mul ? ID_MUL : ID_SWP;
            len_d       = is_mul ? MUL_LEN5 : SWP_LEN5;
            uop_d       = encode(inst_in[24:21], inst_in[20:17],
                                 inst_in[16:13], is_mul ? ID_MUL : ID_SWP,
                                 5'd0);
            uop_valid_d = 1'b1;
            step_d      = 5'd1;
            control_c   = 1'b1;
            state_d     = ST_RUN;
          end else begin
            uop_d       = inst_in;
            uop_valid_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (flush) begin
          // Squash the rest of the sequence. DONE still follows, so the
          // macro that fetch re-presents is not expanded again.
          state_d = ST_DONE;
        end else begin
          uop_d       = encode(rd_q, rs1_q, rs2_q, id_q, step_q);
          uop_valid_d = 1'b1;
          step_d      = step_q + 5'd1;
          if (last_step) begin
            state_d = ST_DONE;
          end else begin
            control_c = 1'b1;
          end
        end
      end
      ST_DONE: begin
        // Fetch advances past the macro in this cycle, so inst_in is ignored.
        step_d  = 5'd0;
        state_d = ST_IDLE;
      end
      default: begin
        step_d  = 5'd0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, latched fields and registered outputs; async reset clears all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      step_q      <= 5'd0;
      rd_q        <= 4'd0;
      rs1_q       <= 4'd0;
      rs2_q       <= 4'd0;
      id_q        <= 3'd0;
      len_q       <= 5'd0;
      uop_q       <= 32'd0;
      uop_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      id_q        <= id_d;
      len_q       <= len_d;
      uop_q       <= uop_d;
      uop_valid_q <= uop_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign control   = control_c & ~rst;
  assign uop       = uop_q;
  assign uop_valid = uop_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: directed scenarios with literal expectations,
// followed by random traffic checked against a queue-based behavioural model.
module tb_ucode_sequencer;

  localparam logic [6:0] MUL_OPC = 7'b1010000;
  localparam logic [6:0] SWP_OPC = 7'b1010001;
  localparam logic [6:0] UOP_OPC = 7'b1111000;
  localparam int MUL_LEN = 16;
  localparam int SWP_LEN = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_in = 32'd0;
  logic        flush = 1'b0;
  logic        control;
  logic [31:0] uop;
  logic        uop_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Model state: micro-ops still to be issued, plus the pending DONE bubble.
  logic [31:0] exp_q[$];
  bit          bubble = 1'b0;
  logic        exp_busy = 1'b0;

  ucode_sequencer #(
    .MUL_OPC(MUL_OPC), .SWP_OPC(SWP_OPC), .UOP_OPC(UOP_OPC),
    .MUL_LEN(MUL_LEN), .SWP_LEN(SWP_LEN)
  ) dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .flush(flush),
    .control(control), .uop(uop), .uop_valid(uop_valid), .busy(busy)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [3:0] rd,
                                          input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 13'd0};
  endfunction

  function automatic logic [31:0] mk_uop(input logic [31:0] inst, input logic [2:0] id,
                                         input int s);
    logic [4:0] s5;
    s5 = 5'(s);
    return {UOP_OPC, inst[24:13], id, s5, 5'd0};
  endfunction

  // Behavioural model for one cycle: returns the expected control level now,
  // and the uop/valid that must appear after the coming edge.
  task automatic model_step(input logic [31:0] inst, input logic fl,
                            output logic ctl, output logic [31:0] nu, output logic nv);
    int len;
    logic [2:0] id;
    ctl = 1'b0; nu = 32'd0; nv = 1'b0;
    if (exp_q.size() > 0) begin
      if (fl) begin
        exp_q.delete();
        bubble = 1'b1;
      end else begin
        ctl = (exp_q.size() > 1);
        nu  = exp_q.pop_front();
        nv  = 1'b1;
        if (exp_q.size() == 0) bubble = 1'b1;
      end
    end else if (bubble) begin
      bubble = 1'b0;
    end else if (!fl) begin
      if (inst[31:25] == MUL_OPC || inst[31:25] == SWP_OPC) begin
        len = (inst[31:25] == MUL_OPC) ? MUL_LEN : SWP_LEN;
        id  = (inst[31:25] == MUL_OPC) ? 3'b001 : 3'b010;
        for (int s = 0; s < len; s++) exp_q.push_back(mk_uop(inst, id, s));
        ctl = 1'b1;
        nu  = exp_q.pop_front();
        nv  = 1'b1;
      end else begin
        nu = inst;
        nv = 1'b1;
      end
    end
    exp_busy = (exp_q.size() > 0) || bubble;
  endtask

  // One clock cycle: drive inputs, check combinational control, then check
  // the registered outputs just after the edge. Returns the sampled values.
  task automatic cycle(input logic [31:0] inst, input logic fl,
                       output logic c, output logic [31:0] u, output logic v);
    logic ctl, nv;
    logic [31:0] nu;
    inst_in = inst;
    flush   = fl;
    #1;
    model_step(inst, fl, ctl, nu, nv);
    c = control;
    chk("control", {31'd0, control}, {31'd0, ctl});
    @(posedge clk);
    #1;
    u = uop;
    v = uop_valid;
    chk("uop", uop, nu);
    chk("uop_valid", {31'd0, uop_valid}, {31'd0, nv});
    chk("busy", {31'd0, busy}, {31'd0, exp_busy});
  endtask

  task automatic model_reset();
    exp_q.delete();
    bubble   = 1'b0;
    exp_busy = 1'b0;
  endtask

  initial begin
    logic c, v;
    logic [31:0] u;
    logic [31:0] swp, mul, other;
    int nvalid, nctl;

    // Reset state.
    rst = 1'b1;
    inst_in = mk_inst(MUL_OPC, 4'd1, 4'd2, 4'd3);
    #2;
    chk("rst_uop", uop, 32'd0);
    chk("rst_valid", {31'd0, uop_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_control", {31'd0, control}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Pass-through.
    cycle(32'h12345678, 1'b0, c, u, v);
    chk("pt_ctl", {31'd0, c}, 32'd0);
    chk("pt_uop", u, 32'h12345678);
    chk("pt_busy", {31'd0, busy}, 32'd0);

    // SWP rd=3 rs1=5 rs2=7, held on inst_in.
    swp = mk_inst(SWP_OPC, 4'd3, 4'd5, 4'd7);
    cycle(swp, 1'b0, c, u, v);
    chk("swp_ctl0", {31'd0, c}, 32'd1);
    chk("swp_uop0", u, 32'hF06AE800);
    cycle(swp, 1'b0, c, u, v);
    chk("swp_ctl1", {31'd0, c}, 32'd1);
    chk("swp_uop1", u, 32'hF06AE820);
    cycle(swp, 1'b0, c, u, v);
    chk("swp_ctl2", {31'd0, c}, 32'd0);
    chk("swp_uop2", u, 32'hF06AE840);
    cycle(swp, 1'b0, c, u, v);
    chk("swp_done_ctl", {31'd0, c}, 32'd0);
    chk("swp_done_valid", {31'd0, v}, 32'd0);
    cycle(swp, 1'b0, c, u, v);
    chk("swp_redetect_ctl", {31'd0, c}, 32'd1);
    for (int i = 0; i < 3; i++) cycle(32'h00000013, 1'b0, c, u, v);

    // MUL rd=1 rs1=2 rs2=4 with default length.
    mul = mk_inst(MUL_OPC, 4'd1, 4'd2, 4'd4);
    nvalid = 0;
    nctl = 0;
    for (int i = 0; i < MUL_LEN; i++) begin
      cycle(mul, 1'b0, c, u, v);
      nvalid += int'(v);
      nctl += int'(c);
    end
    chk("mul_nvalid", 32'(nvalid), 32'd16);
    chk("mul_nctl", 32'(nctl), 32'd15);
    chk("mul_last_uop", u, 32'hF02485E0);
    cycle(mul, 1'b0, c, u, v);
    chk("mul_bubble_valid", {31'd0, v}, 32'd0);
    cycle(32'h00000013, 1'b0, c, u, v);

    // Flush at RUN step 2 of MUL.
    nvalid = 0;
    cycle(mul, 1'b0, c, u, v); nvalid += int'(v);
    cycle(mul, 1'b0, c, u, v); nvalid += int'(v);
    cycle(mul, 1'b1, c, u, v); nvalid += int'(v);
    chk("flush_ctl", {31'd0, c}, 32'd0);
    chk("flush_valid", {31'd0, v}, 32'd0);
    cycle(mul, 1'b0, c, u, v); nvalid += int'(v);
    chk("flush_done_ctl", {31'd0, c}, 32'd0);
    chk("flush_nvalid", 32'(nvalid), 32'd2);
    cycle(32'h00000033, 1'b0, c, u, v);
    chk("flush_idle_pt", u, 32'h00000033);

    // Flush in IDLE with a macro present.
    cycle(mul, 1'b1, c, u, v);
    chk("idle_flush_ctl", {31'd0, c}, 32'd0);
    chk("idle_flush_valid", {31'd0, v}, 32'd0);
    chk("idle_flush_busy", {31'd0, busy}, 32'd0);

    // Async reset in the middle of a SWP expansion.
    cycle(swp, 1'b0, c, u, v);
    cycle(swp, 1'b0, c, u, v);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_uop", uop, 32'd0);
    chk("arst_valid", {31'd0, uop_valid}, 32'd0);
    chk("arst_control", {31'd0, control}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle(32'h0badf00d, 1'b0, c, u, v);
    chk("arst_resume_uop", u, 32'h0badf00d);
    chk("arst_resume_valid", {31'd0, v}, 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      other = $urandom;
      if (sel < 20) other[31:25] = MUL_OPC;
      else if (sel < 40) other[31:25] = SWP_OPC;
      cycle(other, ($urandom_range(0, 99) < 8), c, u, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
